// File: rtl/bus_pkg.sv
// Shared definitions for the transmit framer: FSM states, endpoint IDs and header layout.
package bus_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned BUF_MAX = 16;

  localparam int unsigned HDR_LEN_LSB  = 0;
  localparam int unsigned HDR_DEST_LSB = 4;
  localparam int unsigned HDR_SRC_LSB  = 6;

  localparam logic [ID_W-1:0] SHA_ID  = 2'b01;
  localparam logic [ID_W-1:0] AES_ID  = 2'b00;
  localparam logic [ID_W-1:0] CTRL_ID = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    HDR      = 3'd2,
    PAY      = 3'd3,
    CSUM     = 3'd4,
    WAIT_ACK = 3'd5,
    DONE     = 3'd6,
    DROP     = 3'd7
  } tx_state_e;

  // Header byte: {src, dest, payload length - 1}.
  function automatic logic [BYTE_W-1:0] build_hdr(input logic [ID_W-1:0]  src,
                                                  input logic [ID_W-1:0]  dest,
                                                  input logic [LEN_W-1:0] len_m1);
    logic [BYTE_W-1:0] h;
    h = '0;
    h[HDR_SRC_LSB +: ID_W]   = src;
    h[HDR_DEST_LSB +: ID_W]  = dest;
    h[HDR_LEN_LSB +: LEN_W]  = len_m1;
    return h;
  endfunction

endpackage

// File: rtl/tx_frame_buf.sv
// Payload register file; random-access read so a frame can be re-read for retransmission.
module tx_frame_buf
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH = BUF_MAX
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [LEN_W-1:0]  wr_idx_i,
  input  logic [BYTE_W-1:0] wr_data_i,
  input  logic [LEN_W-1:0]  rd_idx_i,
  output logic [BYTE_W-1:0] rd_data_o_c
);

  logic [BYTE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o_c = mem_q[rd_idx_i];

endmodule

// File: rtl/bus_tx_framer.sv
// Transmit framer: buffers a payload frame, sends header/payload/checksum, retries on ack timeout.
module bus_tx_framer
  import bus_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   src_id,
  input  logic [ID_W-1:0]   dest_id,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              send_valid,
  output logic [BYTE_W-1:0] send_data,
  input  logic              send_ready,
  input  logic              ack,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  localparam int unsigned TMR_W   = 8;
  localparam int unsigned RETRY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

  tx_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [BYTE_W-1:0]  csum_q, csum_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [ID_W-1:0]    dest_q, dest_d;

  logic               in_ready_q, in_ready_d;
  logic               send_valid_q, send_valid_d;
  logic [BYTE_W-1:0]  send_data_q, send_data_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               err_q, err_d;

  logic               accept_c;
  logic               xfer_c;
  logic               buf_we_c;
  logic [LEN_W-1:0]   buf_widx_c;
  logic [BYTE_W-1:0]  buf_rdata_c;
  logic [CNT_W-1:0]   cnt_inc_c;

  assign accept_c  = in_valid && in_ready_q;
  assign xfer_c    = send_valid_q && send_ready;
  assign cnt_inc_c = cnt_q + CNT_W'(1);

  tx_frame_buf #(
    .DEPTH (MAX_LEN)
  ) u_buf (
    .clk         (clk),
    .wr_en_i     (buf_we_c),
    .wr_idx_i    (buf_widx_c),
    .wr_data_i   (in_data),
    .rd_idx_i    (idx_d),
    .rd_data_o_c (buf_rdata_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    retry_d    = retry_q;
    timer_d    = timer_q;
    dest_d     = dest_q;
    buf_we_c   = 1'b0;
    buf_widx_c = LEN_W'(cnt_q);

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          buf_we_c   = 1'b1;
          buf_widx_c = '0;
          dest_d     = dest_id;
          cnt_d      = CNT_W'(1);
          state_d    = (in_last || MAX_LEN == 1) ? HDR : FILL;
        end
      end
      FILL: begin
        if (accept_c) begin
          buf_we_c = 1'b1;
          cnt_d    = cnt_inc_c;
          if (in_last || cnt_inc_c == CNT_W'(MAX_LEN)) begin
            state_d = HDR;
          end
        end
      end
      HDR: begin
        if (xfer_c) begin
          csum_d  = send_data_q;
          idx_d   = '0;
          state_d = PAY;
        end
      end
      PAY: begin
        // Checksum folds in the byte actually leaving on the bus.
        if (xfer_c) begin
          csum_d = csum_q ^ send_data_q;
          if (idx_q == LEN_W'(cnt_q - CNT_W'(1))) begin
            state_d = CSUM;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end
      CSUM: begin
        if (xfer_c) begin
          timer_d = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        timer_d = timer_q + TMR_W'(1);
        if (ack) begin
          state_d = DONE;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = HDR;
          end else begin
            state_d = DROP;
          end
        end
      end
      DONE, DROP: begin
        cnt_d   = '0;
        retry_d = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state so every port comes straight from a flop.
  always_comb begin
    in_ready_d   = 1'b0;
    send_valid_d = 1'b0;
    send_data_d  = '0;
    busy_d       = (state_d != IDLE);
    frame_done_d = 1'b0;
    err_d        = 1'b0;

    case (state_d)
      IDLE, FILL: begin
        in_ready_d = 1'b1;
      end
      HDR: begin
        send_valid_d = 1'b1;
        send_data_d  = build_hdr(src_id, dest_d, LEN_W'(cnt_d - CNT_W'(1)));
      end
      PAY: begin
        send_valid_d = 1'b1;
        send_data_d  = buf_rdata_c;
      end
      CSUM: begin
        send_valid_d = 1'b1;
        send_data_d  = csum_d;
      end
      DONE: begin
        frame_done_d = 1'b1;
      end
      DROP: begin
        err_d = 1'b1;
      end
      default: begin
        in_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      csum_q       <= '0;
      retry_q      <= '0;
      timer_q      <= '0;
      dest_q       <= '0;
      in_ready_q   <= 1'b0;
      send_valid_q <= 1'b0;
      send_data_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      csum_q       <= csum_d;
      retry_q      <= retry_d;
      timer_q      <= timer_d;
      dest_q       <= dest_d;
      in_ready_q   <= in_ready_d;
      send_valid_q <= send_valid_d;
      send_data_q  <= send_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign send_valid = send_valid_q;
  assign send_data  = send_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule
